// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : Single-outstanding RV32 load/store unit. It accepts one request
//             from execute and checks alignment and funct3. A legal request
//             becomes one data-memory access with lane-replicated store data
//             and byte enables. The response is a sign/zero-extended load
//             result, or zero for stores and errors.
//  Ports    : clk, rst_n                      - clock, async active-low reset
//             req_valid/req_ready/req_*       - execute-stage request
//             rsp_valid/rsp_ready/rsp_*       - writeback response
//             dmem_req/dmem_gnt/dmem_*        - data-memory request channel
//             dmem_rvalid/dmem_rdata          - data-memory response channel
//  Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_is_store,
   input  logic [2:0]      req_funct3,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   input  logic [4:0]      req_rd,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_rdata,
   output logic [4:0]      rsp_rd,
   output logic            rsp_err,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [3:0]      dmem_be,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic            dmem_gnt,
   input  logic            dmem_rvalid,
   input  logic [XLEN-1:0] dmem_rdata
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   logic [1:0]      state_q, state_d;
   logic [2:0]      funct3_q;
   logic [1:0]      off_q;
   logic            dmem_we_q;
   logic [XLEN-1:0] dmem_addr_q;
   logic [3:0]      dmem_be_q;
   logic [XLEN-1:0] dmem_wdata_q;
   logic [XLEN-1:0] rsp_rdata_q;
   logic [4:0]      rsp_rd_q;
   logic            rsp_err_q;

   logic            w_accept;
   logic            w_misalign;
   logic            w_bad_f3;
   logic            w_req_err;
   logic [3:0]      w_be;
   logic [XLEN-1:0] w_wdata;
   logic [7:0]      w_byte;
   logic [15:0]     w_half;
   logic [XLEN-1:0] w_load_data;

   assign w_accept = req_valid && (state_q == S_IDLE);

   // funct3[1:0] encodes the access size for both loads and stores
   always_comb begin
      w_misalign = 1'b0;
      w_bad_f3   = 1'b0;
      case (req_funct3[1:0])
         2'b01:   w_misalign = req_addr[0];
         2'b10:   w_misalign = |req_addr[1:0];
         default: w_misalign = 1'b0;
      endcase
      if (req_is_store) begin
         w_bad_f3 = (req_funct3 >= 3'b011);
      end else begin
         w_bad_f3 = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
      end
   end

   assign w_req_err = w_misalign || w_bad_f3;

   // Byte enables and lane-replicated write data; loads always read a word
   always_comb begin
      w_be    = 4'hF;
      w_wdata = req_wdata;
      case (req_funct3[1:0])
         2'b00: begin
            w_be    = 4'b0001 << req_addr[1:0];
            w_wdata = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            w_be    = 4'b0011 << req_addr[1:0];
            w_wdata = {2{req_wdata[15:0]}};
         end
         default: begin
            w_be    = 4'hF;
            w_wdata = req_wdata;
         end
      endcase
      if (!req_is_store) begin
         w_be    = 4'hF;
         w_wdata = '0;
      end
   end

   // Lane select for loads; halfword accesses are 2-aligned so off_q[1] suffices
   always_comb begin
      w_byte = 8'h00;
      case (off_q)
         2'd0:    w_byte = dmem_rdata[7:0];
         2'd1:    w_byte = dmem_rdata[15:8];
         2'd2:    w_byte = dmem_rdata[23:16];
         default: w_byte = dmem_rdata[31:24];
      endcase
      w_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (funct3_q)
         F3_B:    w_load_data = {{24{w_byte[7]}}, w_byte};
         F3_H:    w_load_data = {{16{w_half[15]}}, w_half};
         F3_BU:   w_load_data = {24'h000000, w_byte};
         F3_HU:   w_load_data = {16'h0000, w_half};
         default: w_load_data = dmem_rdata;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (w_accept)    state_d = w_req_err ? S_RESP : S_ISSUE;
         S_ISSUE: if (dmem_gnt)    state_d = S_WAIT;
         S_WAIT:  if (dmem_rvalid) state_d = S_RESP;
         S_RESP:  if (rsp_ready)   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         funct3_q     <= 3'b000;
         off_q        <= 2'b00;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= '0;
         dmem_be_q    <= 4'h0;
         dmem_wdata_q <= '0;
         rsp_rdata_q  <= '0;
         rsp_rd_q     <= 5'd0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (w_accept) begin
            funct3_q    <= req_funct3;
            off_q       <= req_addr[1:0];
            rsp_rd_q    <= req_rd;
            rsp_err_q   <= w_req_err;
            rsp_rdata_q <= '0;
            // The memory-side fields only change for requests that reach memory
            if (!w_req_err) begin
               dmem_we_q    <= req_is_store;
               dmem_addr_q  <= {req_addr[XLEN-1:2], 2'b00};
               dmem_be_q    <= w_be;
               dmem_wdata_q <= w_wdata;
            end
         end
         if ((state_q == S_WAIT) && dmem_rvalid) begin
            rsp_rdata_q <= dmem_we_q ? '0 : w_load_data;
         end
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign dmem_req   = (state_q == S_ISSUE);
   assign rsp_valid  = (state_q == S_RESP);
   assign dmem_we    = dmem_we_q;
   assign dmem_addr  = dmem_addr_q;
   assign dmem_be    = dmem_be_q;
   assign dmem_wdata = dmem_wdata_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign rsp_rd     = rsp_rd_q;
   assign rsp_err    = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_unit
//  Purpose  : Directed self-checking bench for load_store_unit. Inputs are
//             driven and outputs sampled on the falling clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_is_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_rd;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic [4:0]  rsp_rd;
   logic        rsp_err;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_gnt;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   load_store_unit #(.XLEN(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_is_store (req_is_store),
      .req_funct3   (req_funct3),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_rd       (req_rd),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_rd       (rsp_rd),
      .rsp_err      (rsp_err),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_addr    (dmem_addr),
      .dmem_be      (dmem_be),
      .dmem_wdata   (dmem_wdata),
      .dmem_gnt     (dmem_gnt),
      .dmem_rvalid  (dmem_rvalid),
      .dmem_rdata   (dmem_rdata)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [4:0] rd);
      req_valid    = 1'b1;
      req_is_store = st;
      req_funct3   = f3;
      req_addr     = addr;
      req_wdata    = wdata;
      req_rd       = rd;
   endtask

   // Full memory transaction with immediate grant and a one-cycle memory reply
   task automatic do_txn(input string tag, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                         input logic [31:0] rdata, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
      drive_req(st, f3, addr, wdata, rd);
      dmem_gnt  = 1'b1;
      rsp_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      check({tag, "_dmem_req"},  {31'b0, dmem_req}, 32'd1);
      check({tag, "_dmem_we"},   {31'b0, dmem_we}, {31'b0, st});
      check({tag, "_dmem_addr"}, dmem_addr, {addr[31:2], 2'b00});
      check({tag, "_dmem_be"},   {28'b0, dmem_be}, {28'b0, exp_be});
      if (st) check({tag, "_dmem_wdata"}, dmem_wdata, exp_wdata);
      check({tag, "_req_ready"}, {31'b0, req_ready}, 32'd0);
      @(negedge clk);
      check({tag, "_wait_req"},  {31'b0, dmem_req}, 32'd0);
      check({tag, "_wait_vld"},  {31'b0, rsp_valid}, 32'd0);
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b1;
      dmem_rdata  = rdata;
      @(negedge clk);
      dmem_rvalid = 1'b0;
      check({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
      check({tag, "_rsp_rdata"}, rsp_rdata, exp_rdata);
      check({tag, "_rsp_err"},   {31'b0, rsp_err}, 32'd0);
      check({tag, "_rsp_rd"},    {27'b0, rsp_rd}, {27'b0, rd});
      @(negedge clk);
      check({tag, "_idle_ready"}, {31'b0, req_ready}, 32'd1);
      check({tag, "_idle_valid"}, {31'b0, rsp_valid}, 32'd0);
   endtask

   // Rejected request: response one cycle after accept, no memory request
   task automatic do_err(input string tag, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr);
      drive_req(st, f3, addr, 32'hFFFF_FFFF, 5'd9);
      dmem_gnt  = 1'b1;
      rsp_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      check({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
      check({tag, "_rsp_err"},   {31'b0, rsp_err}, 32'd1);
      check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
      check({tag, "_rsp_rd"},    {27'b0, rsp_rd}, 32'd9);
      check({tag, "_dmem_req"},  {31'b0, dmem_req}, 32'd0);
      @(negedge clk);
      check({tag, "_idle_ready"}, {31'b0, req_ready}, 32'd1);
      check({tag, "_idle_req"},   {31'b0, dmem_req}, 32'd0);
      dmem_gnt = 1'b0;
   endtask

   initial begin
      rst_n        = 1'b0;
      req_valid    = 1'b0;
      req_is_store = 1'b0;
      req_funct3   = 3'b000;
      req_addr     = 32'd0;
      req_wdata    = 32'd0;
      req_rd       = 5'd0;
      rsp_ready    = 1'b1;
      dmem_gnt     = 1'b0;
      dmem_rvalid  = 1'b0;
      dmem_rdata   = 32'd0;

      // Reset state
      @(negedge clk);
      check("rst_req_ready",  {31'b0, req_ready}, 32'd1);
      check("rst_rsp_valid",  {31'b0, rsp_valid}, 32'd0);
      check("rst_rsp_err",    {31'b0, rsp_err}, 32'd0);
      check("rst_rsp_rdata",  rsp_rdata, 32'd0);
      check("rst_rsp_rd",     {27'b0, rsp_rd}, 32'd0);
      check("rst_dmem_req",   {31'b0, dmem_req}, 32'd0);
      check("rst_dmem_we",    {31'b0, dmem_we}, 32'd0);
      check("rst_dmem_addr",  dmem_addr, 32'd0);
      check("rst_dmem_be",    {28'b0, dmem_be}, 32'd0);
      check("rst_dmem_wdata", dmem_wdata, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Loads and stores with immediate grant
      do_txn("lb_1003",  1'b0, 3'b000, 32'h0000_1003, 32'h0, 5'd5,  32'h80AA_BBCC, 4'hF, 32'h0, 32'hFFFF_FF80);
      do_txn("sh_2002",  1'b1, 3'b001, 32'h0000_2002, 32'h1234_5678, 5'd6, 32'hDEAD_BEEF, 4'b1100, 32'h5678_5678, 32'h0);
      do_txn("sb_2001",  1'b1, 3'b000, 32'h0000_2001, 32'h0000_00A5, 5'd1, 32'h0, 4'b0010, 32'hA5A5_A5A5, 32'h0);
      do_txn("sw_2004",  1'b1, 3'b010, 32'h0000_2004, 32'hCAFE_F00D, 5'd2, 32'h0, 4'hF, 32'hCAFE_F00D, 32'h0);
      do_txn("lw_0010",  1'b0, 3'b010, 32'h0000_0010, 32'h0, 5'd10, 32'h89AB_CDEF, 4'hF, 32'h0, 32'h89AB_CDEF);
      do_txn("lhu_0012", 1'b0, 3'b101, 32'h0000_0012, 32'h0, 5'd11, 32'h9876_0000, 4'hF, 32'h0, 32'h0000_9876);
      do_txn("lh_0010",  1'b0, 3'b001, 32'h0000_0010, 32'h0, 5'd12, 32'h0000_7FFF, 4'hF, 32'h0, 32'h0000_7FFF);
      do_txn("lb_0001",  1'b0, 3'b000, 32'h0000_0001, 32'h0, 5'd13, 32'h0000_4100, 4'hF, 32'h0, 32'h0000_0041);

      // Misaligned and illegal-funct3 requests
      do_err("lw_0006",   1'b0, 3'b010, 32'h0000_0006);
      do_err("lh_0001",   1'b0, 3'b001, 32'h0000_0001);
      do_err("sh_2003",   1'b1, 3'b001, 32'h0000_2003);
      do_err("ld_f3_011", 1'b0, 3'b011, 32'h0000_0000);
      do_err("ld_f3_110", 1'b0, 3'b110, 32'h0000_0000);
      do_err("st_f3_011", 1'b1, 3'b011, 32'h0000_0000);
      do_err("st_f3_100", 1'b1, 3'b100, 32'h0000_0000);

      // Grant withheld for 4 cycles; stray rvalid during IDLE/ISSUE ignored
      drive_req(1'b0, 3'b100, 32'h0000_3001, 32'h0, 5'd7);
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'h1111_1111;
      @(negedge clk);
      req_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("stall_dmem_req",  {31'b0, dmem_req}, 32'd1);
         check("stall_dmem_addr", dmem_addr, 32'h0000_3000);
         check("stall_dmem_be",   {28'b0, dmem_be}, 32'hF);
         check("stall_dmem_we",   {31'b0, dmem_we}, 32'd0);
         check("stall_req_ready", {31'b0, req_ready}, 32'd0);
         if (i == 2) dmem_rvalid = 1'b0;
         if (i == 4) dmem_gnt = 1'b1;
         if (i < 4) @(negedge clk);
      end
      @(negedge clk);
      check("stall_wait_req", {31'b0, dmem_req}, 32'd0);
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'h0000_F200;
      @(negedge clk);
      dmem_rvalid = 1'b0;
      check("stall_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("stall_rsp_rdata", rsp_rdata, 32'h0000_00F2);
      check("stall_rsp_rd",    {27'b0, rsp_rd}, 32'd7);
      @(negedge clk);

      // Response back-pressure for 3 cycles with a competing request
      rsp_ready = 1'b0;
      drive_req(1'b0, 3'b001, 32'h0000_4002, 32'h0, 5'd3);
      dmem_gnt = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'h8001_0000;
      @(negedge clk);
      dmem_rvalid = 1'b0;
      drive_req(1'b1, 3'b010, 32'h0000_6000, 32'h0000_0055, 5'd12);
      for (int i = 0; i < 3; i++) begin
         check("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
         check("bp_rsp_rdata", rsp_rdata, 32'hFFFF_8001);
         check("bp_rsp_rd",    {27'b0, rsp_rd}, 32'd3);
         check("bp_req_ready", {31'b0, req_ready}, 32'd0);
         if (i == 2) rsp_ready = 1'b1;
         if (i < 2) @(negedge clk);
      end
      @(negedge clk);
      check("bp_after_ready", {31'b0, req_ready}, 32'd1);
      check("bp_after_req",   {31'b0, dmem_req}, 32'd0);
      check("bp_after_valid", {31'b0, rsp_valid}, 32'd0);
      req_valid = 1'b0;
      @(negedge clk);

      // Reset pulsed while waiting for the memory reply; late rvalid ignored
      drive_req(1'b0, 3'b010, 32'h0000_5000, 32'h0, 5'd4);
      dmem_gnt = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      check("rstw_issue_req", {31'b0, dmem_req}, 32'd1);
      @(negedge clk);
      dmem_gnt = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("rstw_dmem_req",  {31'b0, dmem_req}, 32'd0);
      check("rstw_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("rstw_req_ready", {31'b0, req_ready}, 32'd1);
      check("rstw_dmem_addr", dmem_addr, 32'd0);
      check("rstw_rsp_rd",    {27'b0, rsp_rd}, 32'd0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'h7777_7777;
      @(negedge clk);
      dmem_rvalid = 1'b0;
      check("rstw_late_valid", {31'b0, rsp_valid}, 32'd0);
      check("rstw_late_ready", {31'b0, req_ready}, 32'd1);
      check("rstw_late_rdata", rsp_rdata, 32'd0);

      // Reset pulsed while the request is outstanding in ISSUE
      drive_req(1'b0, 3'b010, 32'h0000_5004, 32'h0, 5'd8);
      dmem_gnt = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      check("rsti_issue_req", {31'b0, dmem_req}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("rsti_dmem_req",  {31'b0, dmem_req}, 32'd0);
      check("rsti_req_ready", {31'b0, req_ready}, 32'd1);
      #1 rst_n = 1'b1;
      @(negedge clk);

      // Normal operation resumes after reset
      do_txn("lw_post_rst", 1'b0, 3'b010, 32'h0000_0020, 32'h0, 5'd15, 32'h1357_9BDF, 4'hF, 32'h0, 32'h1357_9BDF);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath and address width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port req_valid  input  1  execute-stage request valid.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port req_is_store  input  1  1 = store (STORE opcode), 0 = load (LOAD opcode).
REQ-007 SHALL have port req_funct3  input  3  load/store width code (LB/LH/LW/LBU/LHU, SB/SH/SW encodings).
REQ-008 SHALL have port req_addr  input  XLEN  effective byte address.
REQ-009 SHALL have port req_wdata  input  XLEN  store data, right-aligned.
REQ-010 SHALL have port req_rd  input  5  destination register tag, passed through.
REQ-011 SHALL have port rsp_valid  output  1  writeback result valid.
REQ-012 SHALL have port rsp_ready  input  1  writeback accepts result.
REQ-013 SHALL have port rsp_rdata  output  XLEN  extended load data; 0 for stores and errors.
REQ-014 SHALL have port rsp_rd  output  5  latched req_rd.
REQ-015 SHALL have port rsp_err  output  1  misaligned address or illegal funct3.
REQ-016 SHALL have port dmem_req  output  1  data-memory request.
REQ-017 SHALL have port dmem_we  output  1  write enable.
REQ-018 SHALL have port dmem_addr  output  XLEN  word address, bits [1:0] forced to 0.
REQ-019 SHALL have port dmem_be  output  4  byte enables.
REQ-020 SHALL have port dmem_wdata  output  XLEN  lane-replicated store data.
REQ-021 SHALL have port dmem_gnt  input  1  request accepted by memory.
REQ-022 SHALL have port dmem_rvalid  input  1  response valid; load data or store acknowledge.
REQ-023 SHALL have port dmem_rdata  input  XLEN  load word.

Function
REQ-024 SHALL implement the FSM IDLE, ISSUE, WAIT, RESP; only one transaction is in flight at a time.
REQ-025 SHALL drive req_ready=1 only in IDLE; a handshake (req_valid & req_ready) latches all req_* fields.
REQ-026 SHALL classify a request as an error when any of the following holds: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; load funct3 in {011,110,111}; store funct3 >= 011.
REQ-027 SHALL, on an error, go IDLE->RESP with rsp_err=1 and rsp_rdata=0, and never assert dmem_req.
REQ-028 SHALL otherwise go IDLE->ISSUE and hold dmem_req=1 with dmem_we, dmem_addr, dmem_be and dmem_wdata stable until dmem_gnt=1, then go to WAIT.
REQ-029 SHALL set byte enables as follows: SB -> 4'b0001<<addr[1:0]; SH -> 4'b0011<<addr[1:0]; SW -> 4'b1111; loads -> 4'b1111.
REQ-030 SHALL set store data as follows: SB -> {4{wdata[7:0]}}; SH -> {2{wdata[15:0]}}; SW -> wdata.
REQ-031 SHALL sample dmem_rvalid only in WAIT; on dmem_rvalid=1 it captures the result and goes to RESP.
REQ-032 SHALL form the load result by selecting the byte/half at addr[1:0], then sign-extending (LB, LH) or zero-extending (LBU, LHU); LW passes the word through unchanged.
REQ-033 SHALL hold rsp_valid=1 and rsp_* stable in RESP until rsp_ready=1, then return to IDLE; the next request is accepted no earlier than the following cycle.
REQ-034 SHALL deliver rsp_valid at the earliest 3 cycles after the accept edge for a memory access (gnt in the ISSUE cycle, rvalid on the next cycle), and 1 cycle after it for an error.
REQ-035 SHALL ignore dmem_rvalid in IDLE, ISSUE and RESP.

Reset
REQ-036 SHALL, while rst_n=0, force state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, rsp_rd=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0 and dmem_wdata=0, asynchronously.
REQ-037 SHALL abandon any in-flight transaction when reset asserts mid-operation, with no response produced and dmem_req deasserting immediately.

Verification
REQ-038 SHALL be tested with LB at addr 0x1003 where dmem_rdata=0x80AA_BBCC -> dmem_be=4'hF, dmem_addr=0x1000, rsp_rdata=0xFFFF_FF80, rsp_err=0.
REQ-039 SHALL be tested with SH at addr 0x2002 and wdata=0x1234_5678 -> dmem_we=1, dmem_be=4'b1100, dmem_wdata=0x5678_5678.
REQ-040 SHALL be tested with LW at addr 0x0006 -> rsp_err=1 one cycle after accept, dmem_req never high.
REQ-041 SHALL be tested with dmem_gnt withheld for 4 cycles -> dmem_req and all dmem_* fields stable for 5 cycles, req_ready=0 throughout.
REQ-042 SHALL be tested with rsp_ready=0 for 3 cycles in RESP -> rsp_valid and rsp_rdata held, and a new req_valid not accepted.
REQ-043 SHALL be tested with rst_n pulsed low in WAIT -> dmem_req=0, rsp_valid=0 and req_ready=1 immediately, and a late dmem_rvalid ignored.
